health_manager: RTL

HEALTH_MANAGER -- requirements
Module: health_manager

---
 rtl/health_manager.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/health_manager.sv
// Player health / invulnerability / death controller, evaluated once per video frame.
// Optional macro HEALTH_REGEN_EN adds hit-free-frame health regeneration.
module health_manager #(
    parameter int MAX_HEALTH    = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int REGEN_FRAMES  = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       hit,
    input  logic       heal,
    input  logic       restart,
    output logic [3:0] present_health,
    output logic       invuln,
    output logic       blink,
    output logic       game_over,
    output logic       hit_ack
);

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_DEAD   = 2'd2
    } state_t;

    localparam logic [3:0] MAX_H    = 4'(MAX_HEALTH);
    localparam logic [7:0] INV_LAST = 8'(INVULN_FRAMES - 1);

    state_t      state_r, state_s;
    logic [3:0]  health_r, health_s;
    logic [7:0]  inv_cnt_r, inv_cnt_s;
    logic        hit_pend_r, hit_pend_s;
    logic        heal_pend_r, heal_pend_s;
    logic        hit_ack_r, hit_ack_s;
    logic        invuln_r, invuln_s;
    logic        blink_r, blink_s;
    logic        game_over_r, game_over_s;
    logic        hit_ev_s, heal_ev_s, regen_inc_s;
`ifdef HEALTH_REGEN_EN
    logic [9:0]  regen_cnt_r, regen_cnt_s;
`else
    logic        unused_regen_s;
    assign unused_regen_s = (REGEN_FRAMES > 0);
`endif

    // Saturating +1 so health can never exceed MAX_HEALTH
    function automatic logic [3:0] sat_inc(input logic [3:0] h);
        if (h >= MAX_H) begin
            return MAX_H;
        end else begin
            return h + 4'd1;
        end
    endfunction

    // State, health and counter register bank
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_ALIVE;
            health_r    <= MAX_H;
            inv_cnt_r   <= 8'd0;
            hit_pend_r  <= 1'b0;
            heal_pend_r <= 1'b0;
            hit_ack_r   <= 1'b0;
            invuln_r    <= 1'b0;
            blink_r     <= 1'b0;
            game_over_r <= 1'b0;
`ifdef HEALTH_REGEN_EN
            regen_cnt_r <= 10'd0;
`endif
        end else begin
            state_r     <= state_s;
            health_r    <= health_s;
            inv_cnt_r   <= inv_cnt_s;
            hit_pend_r  <= hit_pend_s;
            heal_pend_r <= heal_pend_s;
            hit_ack_r   <= hit_ack_s;
            invuln_r    <= invuln_s;
            blink_r     <= blink_s;
            game_over_r <= game_over_s;
`ifdef HEALTH_REGEN_EN
            regen_cnt_r <= regen_cnt_s;
`endif
        end
    end

    // Next-state: latch events during the frame, resolve them on frame_tick
    always_comb begin
        state_s     = state_r;
        health_s    = health_r;
        inv_cnt_s   = inv_cnt_r;
        hit_ack_s   = 1'b0;
        regen_inc_s = 1'b0;
        hit_ev_s    = hit_pend_r | hit;
        heal_ev_s   = heal_pend_r | heal;
        hit_pend_s  = hit_ev_s;
        heal_pend_s = heal_ev_s;
`ifdef HEALTH_REGEN_EN
        regen_cnt_s = regen_cnt_r;
`endif
        if (restart) begin
            state_s     = ST_ALIVE;
            health_s    = MAX_H;
            inv_cnt_s   = 8'd0;
            hit_pend_s  = 1'b0;
            heal_pend_s = 1'b0;
`ifdef HEALTH_REGEN_EN
            regen_cnt_s = 10'd0;
`endif
        end else if (frame_tick) begin
            hit_pend_s  = 1'b0;
            heal_pend_s = 1'b0;
            case (state_r)
                ST_ALIVE: begin
                    if (hit_ev_s) begin
                        // A hit wins over a same-frame heal
                        hit_ack_s = 1'b1;
`ifdef HEALTH_REGEN_EN
                        regen_cnt_s = 10'd0;
`endif
                        if (health_r <= 4'd1) begin
                            health_s = 4'd0;
                            state_s  = ST_DEAD;
                        end else begin
                            health_s  = health_r - 4'd1;
                            state_s   = ST_INVULN;
                            inv_cnt_s = INV_LAST;
                        end
                    end else begin
`ifdef HEALTH_REGEN_EN
                        if (health_r >= MAX_H) begin
                            regen_cnt_s = 10'd0;
                        end else if (regen_cnt_r == 10'(REGEN_FRAMES - 1)) begin
                            regen_cnt_s = 10'd0;
                            regen_inc_s = 1'b1;
                        end else begin
                            regen_cnt_s = regen_cnt_r + 10'd1;
                        end
`endif
                        if (heal_ev_s || regen_inc_s) begin
                            health_s = sat_inc(health_r);
                        end else begin
                            health_s = health_r;
                        end
                    end
                end
                ST_INVULN: begin
`ifdef HEALTH_REGEN_EN
                    regen_cnt_s = 10'd0;
`endif
                    if (heal_ev_s) begin
                        health_s = sat_inc(health_r);
                    end else begin
                        health_s = health_r;
                    end
                    if (inv_cnt_r == 8'd0) begin
                        state_s = ST_ALIVE;
                    end else begin
                        inv_cnt_s = inv_cnt_r - 8'd1;
                    end
                end
                ST_DEAD: begin
                    health_s = 4'd0;
                end
                default: begin
                    state_s   = ST_ALIVE;
                    health_s  = MAX_H;
                    inv_cnt_s = 8'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Output decode from the next state so every output comes straight from a flop
    always_comb begin
        invuln_s    = (state_s == ST_INVULN);
        blink_s     = invuln_s & inv_cnt_s[2];
        game_over_s = (state_s == ST_DEAD);
    end

    assign present_health = health_r;
    assign invuln         = invuln_r;
    assign blink          = blink_r;
    assign game_over      = game_over_r;
    assign hit_ack        = hit_ack_r;

endmodule
